// File: rtl/bit_stream_serializer_if.sv
// Parallel-word handshake plus serial stream and framing strobes of the bit stream serializer.
interface bit_stream_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             serial_out;
  logic             bit_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output data_in, data_valid,
    input  data_ready, serial_out, bit_valid, word_done, busy
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, serial_out, bit_valid, word_done, busy
  );
endinterface

// File: rtl/bit_stream_serializer.sv
// Loads a parallel word on a valid/ready accept and shifts it out one bit per clock,
// chaining words with no gap when the next one is offered on the last-bit cycle.
module bit_stream_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input logic                    clk,
  input logic                    reset,
  bit_stream_serializer_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               serial_q, serial_d;
  logic               bit_valid_q, bit_valid_d;
  logic               word_done_q, word_done_d;
  logic               ready;
  logic               accept;

  assign ready  = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && (cnt_q == '0));
  assign accept = ready && bus.data_valid;

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      serial_q    <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      serial_q    <= serial_d;
      bit_valid_q <= bit_valid_d;
      word_done_q <= word_done_d;
    end
  end

  // Next-state: shreg holds only the bits not yet presented, aligned so the next one
  // sits at the end selected by MSB_FIRST.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    serial_d    = serial_q;
    bit_valid_d = bit_valid_q;
    word_done_d = 1'b0;

    if (accept) begin
      state_d     = ST_SHIFT;
      cnt_d       = CNT_W'(WIDTH - 1);
      bit_valid_d = 1'b1;
      if (MSB_FIRST) begin
        serial_d = bus.data_in[WIDTH-1];
        shreg_d  = {bus.data_in[WIDTH-2:0], 1'b0};
      end else begin
        serial_d = bus.data_in[0];
        shreg_d  = {1'b0, bus.data_in[WIDTH-1:1]};
      end
    end else if ((state_q == ST_SHIFT) && (cnt_q != '0)) begin
      cnt_d       = CNT_W'(cnt_q - CNT_W'(1));
      word_done_d = (cnt_q == CNT_W'(1));
      if (MSB_FIRST) begin
        serial_d = shreg_q[WIDTH-1];
        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        serial_d = shreg_q[0];
        shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
      end
    end else if (state_q == ST_SHIFT) begin
      state_d     = ST_IDLE;
      shreg_d     = '0;
      serial_d    = IDLE_BIT;
      bit_valid_d = 1'b0;
    end
  end

  assign bus.data_ready = ready;
  assign bus.serial_out = serial_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.word_done  = word_done_q;
  assign bus.busy       = (state_q == ST_SHIFT);
endmodule

// File: tb/tb_bit_stream_serializer.sv
// Drives an MSB-first and an LSB-first serializer with identical stimulus and compares both
// against a queue-of-pending-bits model every cycle.
module tb_bit_stream_serializer;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         dval;

  int checks   = 0;
  int failures = 0;

  // Model: bits accepted but not yet shown, and the bit shown in the current cycle.
  bit rest_m[$];
  bit rest_l[$];
  bit cur_valid = 1'b0;
  bit cur_m     = 1'b0;
  bit cur_l     = 1'b0;

  always #5 clk = ~clk;

  bit_stream_serializer_if #(.WIDTH(W)) bus_m ();
  bit_stream_serializer_if #(.WIDTH(W)) bus_l ();

  assign bus_m.data_in    = din;
  assign bus_m.data_valid = dval;
  assign bus_l.data_in    = din;
  assign bus_l.data_valid = dval;

  bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  bit_stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  // {ready, serial, bit_valid, word_done, busy} for MSB-first then LSB-first instance
  function automatic logic [9:0] obs();
    return {bus_m.data_ready, bus_m.serial_out, bus_m.bit_valid, bus_m.word_done, bus_m.busy,
            bus_l.data_ready, bus_l.serial_out, bus_l.bit_valid, bus_l.word_done, bus_l.busy};
  endfunction

  function automatic logic [9:0] expv();
    logic empty;
    empty = (rest_m.size() == 0);
    return {empty, cur_valid & cur_m, cur_valid, cur_valid & empty, cur_valid,
            empty, cur_valid & cur_l, cur_valid, cur_valid & empty, cur_valid};
  endfunction

  task automatic model_clear();
    rest_m.delete();
    rest_l.delete();
    cur_valid = 1'b0;
    cur_m     = 1'b0;
    cur_l     = 1'b0;
  endtask

  // One clock: a word is taken when offered while nothing is pending beyond the current bit.
  task automatic tick();
    bit           acc;
    logic [W-1:0] w;
    acc = (dval === 1'b1) && (rest_m.size() == 0);
    w   = din;
    @(posedge clk);
    if (acc) begin
      for (int i = 0; i < int'(W); i++) begin
        rest_m.push_back(w[W-1-i]);
        rest_l.push_back(w[i]);
      end
    end
    cur_valid = (rest_m.size() != 0);
    if (cur_valid) begin
      cur_m = rest_m.pop_front();
      cur_l = rest_l.pop_front();
    end
    #1;
  endtask

  task automatic test_reset();
    dval = 1'b0;
    din  = '0;
    repeat (2) tick();
    #3 reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", obs(), expv());
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL reset_held got=%b exp=%b", obs(), expv());
    end
    #3 reset = 1'b1;
    tick();
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", obs(), expv());
    end
  endtask

  task automatic test_single();
    logic       s [0:9];
    logic [7:0] seq;
    int         hits;
    int         pos;
    din  = 8'hA0;
    dval = 1'b1;
    s[0] = bus_m.serial_out;
    tick();
    dval = 1'b0;
    din  = W'($urandom);
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL single cyc%0d got=%b exp=%b", c, obs(), expv());
      end
      s[c] = bus_m.serial_out;
      if (c < 9) tick();
    end
    for (int i = 1; i <= 8; i++) seq[8-i] = s[i];
    checks++;
    if (seq !== 8'b1010_0000) begin
      failures++;
      $display("FAIL single_seq got=%b exp=10100000", seq);
    end
    hits = 0;
    pos  = -1;
    for (int i = 2; i <= 9; i++) begin
      if (s[i-2] === 1'b1 && s[i-1] === 1'b0 && s[i] === 1'b1) begin
        hits++;
        pos = i;
      end
    end
    checks++;
    if (hits != 1 || pos != 3) begin
      failures++;
      $display("FAIL single_detect got hits=%0d pos=%0d exp hits=1 pos=3", hits, pos);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq;
    logic [15:0] rdy;
    logic        bv_all;
    din    = 8'hA5;
    dval   = 1'b1;
    bv_all = 1'b1;
    tick();
    dval = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 8) begin
        din  = 8'h5A;
        dval = 1'b1;
      end else if (c == 9) begin
        dval = 1'b0;
        din  = W'($urandom);
      end
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL b2b cyc%0d got=%b exp=%b", c, obs(), expv());
      end
      seq[16-c] = bus_m.serial_out;
      rdy[16-c] = bus_m.data_ready;
      bv_all    = bv_all & bus_m.bit_valid;
      tick();
    end
    checks++;
    if (seq !== 16'b10100101_01011010 || bv_all !== 1'b1) begin
      failures++;
      $display("FAIL b2b_seq got=%b bv=%b exp=1010010101011010 bv=1", seq, bv_all);
    end
    checks++;
    if (rdy !== 16'b00000001_00000001) begin
      failures++;
      $display("FAIL b2b_ready got=%b exp=0000000100000001", rdy);
    end
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL b2b_idle got=%b exp=%b", obs(), expv());
    end
  endtask

  task automatic test_hold_off();
    din  = W'($urandom);
    dval = 1'b1;
    tick();
    dval = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c >= 2 && c <= 7) begin
        dval = 1'b1;
        din  = W'($urandom);
      end else begin
        dval = 1'b0;
      end
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL hold_off cyc%0d got=%b exp=%b", c, obs(), expv());
      end
      tick();
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] seq;
    din  = 8'h05;
    dval = 1'b1;
    tick();
    dval = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL lsb cyc%0d got=%b exp=%b", c, obs(), expv());
      end
      if (c <= 8) seq[8-c] = bus_l.serial_out;
      tick();
    end
    checks++;
    if (seq !== 8'b1010_0000) begin
      failures++;
      $display("FAIL lsb_seq got=%b exp=10100000", seq);
    end
  endtask

  task automatic test_async_reset();
    din  = W'($urandom);
    dval = 1'b1;
    tick();
    dval = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL areset_pre cyc%0d got=%b exp=%b", c, obs(), expv());
      end
      if (c < 4) tick();
    end
    #3 reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL areset_clear got=%b exp=%b", obs(), expv());
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_m.word_done !== 1'b0 || bus_l.word_done !== 1'b0 || obs() !== expv()) begin
      failures++;
      $display("FAIL areset_nodone got=%b exp=%b", obs(), expv());
    end
    #3 reset = 1'b1;
    tick();
    din  = W'($urandom);
    dval = 1'b1;
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL areset_ready got=%b exp=%b", obs(), expv());
    end
    tick();
    dval = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL areset_fresh cyc%0d got=%b exp=%b", c, obs(), expv());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      dval = ($urandom_range(0, 3) != 0);
      din  = W'($urandom);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL random cyc%0d got=%b exp=%b", c, obs(), expv());
      end
      tick();
    end
    dval = 1'b0;
    repeat (W + 1) tick();
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL random_drain got=%b exp=%b", obs(), expv());
    end
  endtask

  initial begin
    reset = 1'b0;
    dval  = 1'b0;
    din   = '0;
    #12 reset = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_off();
    test_lsb_first();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
